alu_control_sequencer: RTL and testbench

Front end that drives the 4-bit arithmetic logic unit's one-hot control inputs and captures its results. It accepts an opcode plus two operands over a valid/ready handshake and decodes the opcode into a single one-hot ALU control pulse. Shifts need two cycles (LSR load, then LSH/RSH). The ALU output, flags and status are registered and presented on a result valid/ready handshake. It sits between the instruction/operand source and the ALU.

---
 rtl/alu_control_sequencer_if.sv | 34 +++
 rtl/alu_control_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_sequencer_if.sv
// rtl/alu_control_sequencer_if.sv - instruction and result handshake bundle for the ALU sequencer
interface alu_control_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int OPC_W  = 4,
    parameter int CNT_W  = 8
);
    // Instruction channel: source -> sequencer
    logic              instr_valid;
    logic              instr_ready;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Result channel: sequencer -> consumer
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_carry;
    logic              res_zero;
    logic              res_illegal;
    logic [CNT_W-1:0]  op_count;

    // Instruction source and result consumer side
    modport master (
        output instr_valid, opcode, op_a, op_b, res_ready,
        input  instr_ready, res_valid, res_data, res_carry, res_zero, res_illegal, op_count
    );

    // Sequencer side
    modport slave (
        input  instr_valid, opcode, op_a, op_b, res_ready,
        output instr_ready, res_valid, res_data, res_carry, res_zero, res_illegal, op_count
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - decodes opcodes into one-hot ALU control pulses and captures results
module alu_control_sequencer #(
    parameter int DATA_W = 4,
    parameter int OPC_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_control_sequencer_if.slave bus,
    output logic [DATA_W-1:0]     alu_in1,
    output logic [DATA_W-1:0]     alu_in2,
    output logic                  alu_add,
    output logic                  alu_sub,
    output logic                  alu_lsr,
    output logic                  alu_lsh,
    output logic                  alu_rsh,
    output logic                  alu_and,
    output logic                  alu_or,
    output logic                  alu_xor,
    output logic                  alu_inv,
    output logic                  alu_clr,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_overflow,
    input  logic                  alu_shift_flag
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [OPC_W-1:0] OPC_ADD = OPC_W'(1);
    localparam logic [OPC_W-1:0] OPC_SUB = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_LSH = OPC_W'(3);
    localparam logic [OPC_W-1:0] OPC_RSH = OPC_W'(4);
    localparam logic [OPC_W-1:0] OPC_AND = OPC_W'(5);
    localparam logic [OPC_W-1:0] OPC_OR  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OPC_XOR = OPC_W'(7);
    localparam logic [OPC_W-1:0] OPC_INV = OPC_W'(8);
    localparam logic [OPC_W-1:0] OPC_CLR = OPC_W'(9);

    // Bit positions inside the control vector
    localparam int C_ADD = 0;
    localparam int C_SUB = 1;
    localparam int C_LSR = 2;
    localparam int C_LSH = 3;
    localparam int C_RSH = 4;
    localparam int C_AND = 5;
    localparam int C_OR  = 6;
    localparam int C_XOR = 7;
    localparam int C_INV = 8;
    localparam int C_CLR = 9;
    localparam int CTRL_W = 10;

    state_t            state_q,       state_d;
    logic [OPC_W-1:0]  opc_q,         opc_d;
    logic [DATA_W-1:0] in1_q,         in1_d;
    logic [DATA_W-1:0] in2_q,         in2_d;
    logic [CTRL_W-1:0] ctrl_q,        ctrl_d;
    logic              instr_ready_q, instr_ready_d;
    logic              res_valid_q,   res_valid_d;
    logic [DATA_W-1:0] res_data_q,    res_data_d;
    logic              res_carry_q,   res_carry_d;
    logic              res_zero_q,    res_zero_d;
    logic              res_illegal_q, res_illegal_d;
    logic [CNT_W-1:0]  op_count_q,    op_count_d;

    // Single-cycle ALU operations map to exactly one control bit
    function automatic logic [CTRL_W-1:0] exec_ctrl(input logic [OPC_W-1:0] opc);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (opc)
            OPC_ADD: c[C_ADD] = 1'b1;
            OPC_SUB: c[C_SUB] = 1'b1;
            OPC_AND: c[C_AND] = 1'b1;
            OPC_OR:  c[C_OR]  = 1'b1;
            OPC_XOR: c[C_XOR] = 1'b1;
            OPC_INV: c[C_INV] = 1'b1;
            OPC_CLR: c[C_CLR] = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic: controls are decoded one cycle early so they leave a flop
    always_comb begin
        state_d       = state_q;
        opc_d         = opc_q;
        in1_d         = in1_q;
        in2_d         = in2_q;
        ctrl_d        = '0;
        instr_ready_d = instr_ready_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_carry_d   = res_carry_q;
        res_zero_d    = res_zero_q;
        res_illegal_d = res_illegal_q;
        op_count_d    = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_ready_q && bus.instr_valid) begin
                    opc_d         = bus.opcode;
                    in1_d         = bus.op_a;
                    in2_d         = bus.op_b;
                    instr_ready_d = 1'b0;
                    case (bus.opcode)
                        OPC_LSH, OPC_RSH: begin
                            state_d        = ST_LOAD;
                            ctrl_d[C_LSR]  = 1'b1;
                        end
                        OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_INV, OPC_CLR: begin
                            state_d = ST_EXEC;
                            ctrl_d  = exec_ctrl(bus.opcode);
                        end
                        default: begin
                            // NOP and illegal opcodes never touch the ALU
                            state_d       = ST_DONE;
                            res_valid_d   = 1'b1;
                            res_data_d    = '0;
                            res_carry_d   = 1'b0;
                            res_zero_d    = 1'b1;
                            res_illegal_d = (bus.opcode > OPC_CLR);
                        end
                    endcase
                end else begin
                    // Also raises ready on the first edge after reset release
                    instr_ready_d = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d       = ST_DONE;
                res_valid_d   = 1'b1;
                res_data_d    = alu_out;
                res_carry_d   = ((opc_q == OPC_ADD) || (opc_q == OPC_SUB)) ? alu_overflow : 1'b0;
                res_zero_d    = (alu_out == '0);
                res_illegal_d = 1'b0;
            end
            ST_LOAD: begin
                // ALU shift register captured in1 on the edge ending this state's predecessor pulse
                state_d = ST_SHIFT;
                if (opc_q == OPC_LSH) begin
                    ctrl_d[C_LSH] = 1'b1;
                end else begin
                    ctrl_d[C_RSH] = 1'b1;
                end
            end
            ST_SHIFT: begin
                state_d       = ST_DONE;
                res_valid_d   = 1'b1;
                res_data_d    = alu_out;
                res_carry_d   = alu_shift_flag;
                res_zero_d    = (alu_out == '0);
                res_illegal_d = 1'b0;
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d       = ST_IDLE;
                    res_valid_d   = 1'b0;
                    instr_ready_d = 1'b1;
                    op_count_d    = op_count_q + 1'b1;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                res_valid_d   = 1'b0;
                instr_ready_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            opc_q         <= '0;
            in1_q         <= '0;
            in2_q         <= '0;
            ctrl_q        <= '0;
            instr_ready_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_carry_q   <= 1'b0;
            res_zero_q    <= 1'b0;
            res_illegal_q <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            opc_q         <= opc_d;
            in1_q         <= in1_d;
            in2_q         <= in2_d;
            ctrl_q        <= ctrl_d;
            instr_ready_q <= instr_ready_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_carry_q   <= res_carry_d;
            res_zero_q    <= res_zero_d;
            res_illegal_q <= res_illegal_d;
            op_count_q    <= op_count_d;
        end
    end

    assign alu_in1 = in1_q;
    assign alu_in2 = in2_q;

    assign alu_add = ctrl_q[C_ADD];
    assign alu_sub = ctrl_q[C_SUB];
    assign alu_lsr = ctrl_q[C_LSR];
    assign alu_lsh = ctrl_q[C_LSH];
    assign alu_rsh = ctrl_q[C_RSH];
    assign alu_and = ctrl_q[C_AND];
    assign alu_or  = ctrl_q[C_OR];
    assign alu_xor = ctrl_q[C_XOR];
    assign alu_inv = ctrl_q[C_INV];
    assign alu_clr = ctrl_q[C_CLR];

    assign bus.instr_ready = instr_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_carry   = res_carry_q;
    assign bus.res_zero    = res_zero_q;
    assign bus.res_illegal = res_illegal_q;
    assign bus.op_count    = op_count_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - self-checking bench for alu_control_sequencer
module tb_alu_control_sequencer;

    logic clk;
    logic reset;

    alu_control_sequencer_if #(.DATA_W(4), .OPC_W(4), .CNT_W(8)) bus ();

    logic [3:0] alu_in1, alu_in2, alu_out;
    logic alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh;
    logic alu_and, alu_or, alu_xor, alu_inv, alu_clr;
    logic alu_overflow, alu_shift_flag;

    alu_control_sequencer #(.DATA_W(4), .OPC_W(4), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .alu_in1        (alu_in1),
        .alu_in2        (alu_in2),
        .alu_add        (alu_add),
        .alu_sub        (alu_sub),
        .alu_lsr        (alu_lsr),
        .alu_lsh        (alu_lsh),
        .alu_rsh        (alu_rsh),
        .alu_and        (alu_and),
        .alu_or         (alu_or),
        .alu_xor        (alu_xor),
        .alu_inv        (alu_inv),
        .alu_clr        (alu_clr),
        .alu_out        (alu_out),
        .alu_overflow   (alu_overflow),
        .alu_shift_flag (alu_shift_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector: add0 sub1 lsr2 lsh3 rsh4 and5 or6 xor7 inv8 clr9
    logic [9:0] ctrl_v;
    assign ctrl_v = {alu_clr, alu_inv, alu_xor, alu_or, alu_and, alu_rsh, alu_lsh, alu_lsr, alu_sub, alu_add};

    // Stand-in ALU: shift register loaded by lsr, combinational result per control
    logic [3:0] alu_sr;
    always @(posedge clk) if (alu_lsr) alu_sr <= alu_in1;

    always_comb begin
        alu_out        = 4'h0;
        alu_overflow   = 1'b0;
        alu_shift_flag = 1'b0;
        if (alu_add) {alu_overflow, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
        if (alu_sub) begin alu_out = alu_in1 - alu_in2; alu_overflow = (alu_in1 < alu_in2); end
        if (alu_lsh) begin alu_out = {alu_sr[2:0], 1'b0}; alu_shift_flag = alu_sr[3]; end
        if (alu_rsh) begin alu_out = {1'b0, alu_sr[3:1]}; alu_shift_flag = alu_sr[0]; end
        if (alu_and) alu_out = alu_in1 & alu_in2;
        if (alu_or)  alu_out = alu_in1 | alu_in2;
        if (alu_xor) alu_out = alu_in1 ^ alu_in2;
        if (alu_inv) alu_out = ~alu_in1;
        if (alu_clr) alu_out = 4'h0;
    end

    int n_vec = 0;
    int n_err = 0;
    int exp_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: result, flags, latency and control-pulse sequence from the opcode table
    task automatic ref_model(input int opc, input int a, input int b,
                             output logic [3:0] d, output logic c, output logic z,
                             output logic il, output int lat, output logic [31:0] tr);
        int r;
        r = 0; c = 1'b0; il = 1'b0; lat = 2; tr = 0;
        case (opc)
            1: begin r = a + b; c = (r > 15); tr = 32'd1; end
            2: begin r = a - b; c = (a < b); tr = 32'd2; end
            3: begin r = a * 2; c = (a >= 8); lat = 3; tr = (32'd4 << 10) | 32'd8; end
            4: begin r = a / 2; c = (a % 2 == 1); lat = 3; tr = (32'd4 << 10) | 32'd16; end
            5: begin r = a & b; tr = 32'd32; end
            6: begin r = a | b; tr = 32'd64; end
            7: begin r = a ^ b; tr = 32'd128; end
            8: begin r = 15 - a; tr = 32'd256; end
            9: begin r = 0; tr = 32'd512; end
            default: begin r = 0; lat = 1; il = (opc >= 10); end
        endcase
        r = (r + 32) % 16;
        d = r[3:0];
        z = (r == 0);
    endtask

    // Issue one instruction, trace the control pulses, check the result, then complete the handshake
    task automatic run_op(input logic [3:0] opc, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] e_data, input logic e_carry, input logic e_zero,
                          input logic e_ill, input int e_lat, input logic [31:0] e_trace,
                          input int hold);
        int guard;
        int lat;
        logic [31:0] trace;
        logic busy_ready;
        logic stable;
        guard = 0;
        while (!bus.instr_ready && guard < 20) begin @(negedge clk); guard++; end
        chk("instr_ready_idle", {31'd0, bus.instr_ready}, 32'd1);
        bus.instr_valid = 1'b1; bus.opcode = opc; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.opcode = 4'($urandom); bus.op_a = 4'($urandom); bus.op_b = 4'($urandom);
        lat = 1; trace = 0; busy_ready = 1'b0;
        @(negedge clk);
        while (!bus.res_valid && lat < 8) begin
            trace = (trace << 10) | {22'd0, ctrl_v};
            busy_ready = busy_ready | bus.instr_ready;
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, e_lat);
        chk("ctrl_trace", trace, e_trace);
        chk("busy_ready", {31'd0, busy_ready}, 32'd0);
        chk("res_data", {28'd0, bus.res_data}, {28'd0, e_data});
        chk("res_carry", {31'd0, bus.res_carry}, {31'd0, e_carry});
        chk("res_zero", {31'd0, bus.res_zero}, {31'd0, e_zero});
        chk("res_illegal", {31'd0, bus.res_illegal}, {31'd0, e_ill});
        chk("done_ctrl", {22'd0, ctrl_v}, 32'd0);
        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                bus.instr_valid = ~bus.instr_valid;
                bus.op_a = 4'($urandom);
                @(negedge clk);
                if (bus.res_data !== e_data || bus.res_valid !== 1'b1 || bus.instr_ready !== 1'b0
                    || bus.op_count !== 8'(exp_count) || ctrl_v !== 10'd0) stable = 1'b0;
            end
            chk("hold_stable", {31'd0, stable}, 32'd1);
            bus.instr_valid = 1'b0;
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        exp_count++;
        chk("op_count", {24'd0, bus.op_count}, exp_count % 256);
        chk("res_valid_clear", {31'd0, bus.res_valid}, 32'd0);
    endtask

    typedef struct {
        logic [3:0] opc;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] data;
        logic       carry;
        logic       zero;
        logic       ill;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] d;
        logic c, z, il;
        int lat;
        logic [31:0] tr;
        logic [3:0] ro, ra, rb;

        vecs[0]  = '{4'd1,  4'h9, 4'h8, 4'h1, 1'b1, 1'b0, 1'b0, 2};
        vecs[1]  = '{4'd2,  4'h3, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 2};
        vecs[2]  = '{4'd3,  4'hA, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 3};
        vecs[3]  = '{4'd4,  4'h3, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0, 3};
        vecs[4]  = '{4'd12, 4'h5, 4'h6, 4'h0, 1'b0, 1'b1, 1'b1, 1};
        vecs[5]  = '{4'd7,  4'hF, 4'h5, 4'hA, 1'b0, 1'b0, 1'b0, 2};
        vecs[6]  = '{4'd0,  4'h7, 4'h7, 4'h0, 1'b0, 1'b1, 1'b0, 1};
        vecs[7]  = '{4'd8,  4'h5, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0, 2};
        vecs[8]  = '{4'd9,  4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 2};
        vecs[9]  = '{4'd6,  4'h4, 4'h2, 4'h6, 1'b0, 1'b0, 1'b0, 2};
        vecs[10] = '{4'd5,  4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 2};
        vecs[11] = '{4'd2,  4'h2, 4'h5, 4'hD, 1'b1, 1'b0, 1'b0, 2};

        bus.instr_valid = 1'b0; bus.opcode = 4'h0; bus.op_a = 4'h0; bus.op_b = 4'h0;
        bus.res_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_data", {28'd0, bus.res_data}, 32'd0);
        chk("rst_ctrl", {22'd0, ctrl_v}, 32'd0);
        chk("rst_alu_in", {24'd0, alu_in1, alu_in2}, 32'd0);
        chk("rst_op_count", {24'd0, bus.op_count}, 32'd0);
        chk("rst_flags", {29'd0, bus.res_carry, bus.res_zero, bus.res_illegal}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, bus.instr_ready}, 32'd1);

        // Directed table; the first entry also holds res_ready low for five cycles
        for (int i = 0; i < 12; i++) begin
            ref_model(vecs[i].opc, vecs[i].a, vecs[i].b, d, c, z, il, lat, tr);
            run_op(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].carry,
                   vecs[i].zero, vecs[i].ill, vecs[i].lat, tr, (i == 0) ? 5 : 0);
        end

        // Reset during the shift pulse aborts the operation
        while (!bus.instr_ready) @(negedge clk);
        bus.instr_valid = 1'b1; bus.opcode = 4'd3; bus.op_a = 4'h6; bus.op_b = 4'h0;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("mid_load_ctrl", {22'd0, ctrl_v}, 32'd4);
        @(negedge clk);
        chk("mid_shift_ctrl", {22'd0, ctrl_v}, 32'd8);
        #1 reset = 1'b1;
        #1;
        chk("abort_ctrl", {22'd0, ctrl_v}, 32'd0);
        chk("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("abort_op_count", {24'd0, bus.op_count}, 32'd0);
        exp_count = 0;
        @(negedge clk);
        reset = 1'b0;
        ref_model(7, 15, 5, d, c, z, il, lat, tr);
        run_op(4'd7, 4'hF, 4'h5, 4'hA, 1'b0, 1'b0, 1'b0, 2, tr, 0);

        // Random instructions against the reference
        for (int k = 0; k < 40; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 4'($urandom);
            rb = 4'($urandom);
            ref_model(ro, ra, rb, d, c, z, il, lat, tr);
            run_op(ro, ra, rb, d, c, z, il, lat, tr, (k % 10 == 3) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
